apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the APB data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the APB address width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum ACCESS wait cycles (used only with the timeout macro).
REQ-004 The block SHALL have port PCLK, input, width 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port PRESET, input, width 1, the reset: asynchronous, active-high.
REQ-006 The block SHALL have port req_valid_i, input, width 1, command valid.
REQ-007 The block SHALL have port req_ready_o, output, width 1, command accepted when both are high.
REQ-008 The block SHALL have port req_write_i, input, width 1, 1=write, 0=read.
REQ-009 The block SHALL have port req_addr_i, input, width ADDR_WIDTH, transfer address.
REQ-010 The block SHALL have port req_wdata_i, input, width DATA_WIDTH, write data.
REQ-011 The block SHALL have port rsp_valid_o, output, width 1, one-cycle completion pulse.
REQ-012 The block SHALL have port rsp_rdata_o, output, width DATA_WIDTH, read data.
REQ-013 The block SHALL have port rsp_err_o, output, width 1, error flag.
REQ-014 The block SHALL have ports PADDR, PSEL, PENABLE, PWRITE and PWDATA, all outputs, widths ADDR_WIDTH, 1, 1, 1 and DATA_WIDTH, forming the APB requester side.
REQ-015 The block SHALL have ports PREADY, PRDATA and PSLVERR, all inputs, widths 1, DATA_WIDTH and 1, forming the APB completer response.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-017 In IDLE, req_ready_o SHALL be 1; in SETUP and ACCESS it SHALL be 0.
REQ-018 In IDLE, when req_valid_i and req_ready_o are both high, the block SHALL register addr, write and wdata into PADDR, PWRITE and PWDATA, and move to SETUP.
REQ-019 In SETUP, PSEL SHALL be 1 and PENABLE 0, and the next state SHALL always be ACCESS.
REQ-020 In ACCESS, PSEL SHALL be 1 and PENABLE 1; with PREADY=0 the block SHALL stay in ACCESS; with PREADY=1 it SHALL go to IDLE.
REQ-021 PADDR, PWRITE and PWDATA SHALL stay stable through SETUP and ACCESS, and SHALL hold their last value in IDLE.
REQ-022 On the edge where PREADY=1 in ACCESS, the block SHALL register rsp_err_o=PSLVERR and rsp_rdata_o, using PRDATA for a read and 0 for a write.
REQ-023 rsp_valid_o SHALL be 1 for exactly the single cycle after completion.
REQ-024 Responses have no backpressure.
REQ-025 rsp_rdata_o and rsp_err_o SHALL hold their values until the next completion.
REQ-026 Latency SHALL be: accept at edge N; SETUP in cycle N+1; ACCESS from cycle N+2; rsp_valid_o in the cycle after the PREADY sample.
REQ-027 The minimum transfer period SHALL be 3 cycles, and a new command SHALL be accepted in the same cycle as rsp_valid_o.
REQ-028 In IDLE, PSEL and PENABLE SHALL be 0.
REQ-029 req_* inputs SHALL be ignored outside IDLE.
REQ-030 PSLVERR and PRDATA SHALL be sampled only in ACCESS with PREADY=1.

Reset
REQ-031 PRESET=1 SHALL asynchronously force IDLE and zero all of the following: PADDR, PWRITE, PWDATA, PSEL, PENABLE, rsp_valid_o, rsp_rdata_o, rsp_err_o and the timeout counter.
REQ-032 req_ready_o SHALL be 1 once reset is released.
REQ-033 A transfer interrupted by reset SHALL be dropped with no response.
REQ-034 Operation SHALL resume on the first rising PCLK edge after PRESET falls.

Configuration
REQ-035 With APB_MASTER_TIMEOUT_EN defined, a counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY=0.
REQ-036 With APB_MASTER_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES and PREADY=0, the block SHALL go to IDLE (PSEL=0, PENABLE=0) and pulse rsp_valid_o next cycle with rsp_err_o=1 and rsp_rdata_o=0.
REQ-037 With APB_MASTER_TIMEOUT_EN defined, PREADY=1 in the same cycle as the timeout SHALL take priority as a normal completion.
REQ-038 Without APB_MASTER_TIMEOUT_EN, the counter SHALL be absent, ACCESS SHALL wait indefinitely for PREADY, and TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-039 Zero-wait write: addr=0x10, wdata=0xDEADBEEF, PREADY tied 1 -> SETUP cycle N+1, ACCESS N+2, rsp_valid_o at N+3 with err=0, rdata=0.
REQ-040 Read with 3 wait states: PRDATA=0xCAFEF00D when PREADY rises -> PENABLE high for 4 cycles, PADDR stable throughout, rsp_rdata_o=0xCAFEF00D.
REQ-041 Error: read with PSLVERR=1 at PREADY -> rsp_err_o=1 for that response; the next clean transfer gives rsp_err_o=0.
REQ-042 Back-to-back: req_valid_i held high for 4 commands -> accepts every 3 cycles, PSEL drops for exactly 1 IDLE cycle between transfers.
REQ-043 Reset mid-ACCESS: PRESET pulsed with PREADY=0 -> PSEL/PENABLE immediately 0, no rsp_valid_o, req_ready_o=1 after release.
REQ-044 With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 5 ACCESS cycles, rsp_err_o=1; PREADY=1 on the timeout cycle -> normal completion instead.

Source files
------------

// File: rtl/apb_master.sv
// apb_master: converts a valid/ready command interface into single APB transfers and
// returns a one-cycle completion pulse carrying read data and an error flag.
//
// Optional build macro: APB_MASTER_TIMEOUT_EN
//   When defined, an ACCESS phase that sees no PREADY for TIMEOUT_CYCLES+1 cycles
//   is aborted and reported as an error response with zero read data.
//
// Ports
//   PCLK, PRESET                  clock (rising edge), asynchronous active-high reset
//   req_valid_i / req_ready_o     command handshake, accepted only in IDLE
//   req_write_i, req_addr_i,
//   req_wdata_i                   command fields (1 = write)
//   rsp_valid_o                   one-cycle completion pulse (no backpressure)
//   rsp_rdata_o, rsp_err_o        response payload, held until the next completion
//   PADDR, PSEL, PENABLE,
//   PWRITE, PWDATA                APB requester outputs
//   PREADY, PRDATA, PSLVERR       APB completer response inputs

module apb_master #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,

  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,

  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,

  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  // Asserted in an ACCESS cycle that must be abandoned for lack of PREADY.
  logic timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == StAccess) && !PREADY && (cnt_q == CntW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StSetup) begin
      // SETUP always leads to ACCESS, so clearing here clears on ACCESS entry.
      cnt_d = '0;
    end else if ((state_q == StAccess) && !PREADY && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;

  // TIMEOUT_CYCLES has no function in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          paddr_d  = req_addr_i;
          pwrite_d = req_write_i;
          pwdata_d = req_wdata_i;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        // PREADY wins over a coincident timeout.
        if (PREADY) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else if (timeout) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= StIdle;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Control outputs decode straight from the state register, so reset clears them at once.
  assign req_ready_o = (state_q == StIdle);
  assign PSEL        = (state_q != StIdle);
  assign PENABLE     = (state_q == StAccess);

  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: table-driven single transfers with a bench-side
// APB completer, plus hand sequences for back-to-back, reset mid-transfer and (when
// APB_MASTER_TIMEOUT_EN is defined) the ACCESS timeout. Responses are checked by a
// scoreboard queue filled when a command is driven.

module tb_apb_master;

  logic        PCLK;
  logic        PRESET;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  apb_master #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_write_i(req_write_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest outstanding expectation.
  always @(negedge PCLK) begin
    if (rsp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid_o=1 required no response at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", {32'h0, rsp_rdata_o}, {32'h0, mon_e.rdata});
        chk("rsp_err", {63'h0, rsp_err_o}, {63'h0, mon_e.err});
      end
    end
  end

  // One transfer, entered and left at a negedge with the DUT in IDLE.
  task automatic run_xfer(input vec_t v);
    int pen;
    chk("ready_idle", {63'h0, req_ready_o}, 64'h1);
    req_valid_i = 1'b1;
    req_write_i = v.wr;
    req_addr_i  = v.addr;
    req_wdata_i = v.wdata;
    PREADY      = 1'b0;
    PSLVERR     = 1'b1;            // junk while not ready, must be ignored
    PRDATA      = 32'hBAD0_BAD0;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    @(negedge PCLK);
    chk("setup_psel", {63'h0, PSEL}, 64'h1);
    chk("setup_penable", {63'h0, PENABLE}, 64'h0);
    chk("setup_ready", {63'h0, req_ready_o}, 64'h0);
    chk("paddr", {32'h0, PADDR}, {32'h0, v.addr});
    chk("pwrite", {63'h0, PWRITE}, {63'h0, v.wr});
    chk("pwdata", {32'h0, PWDATA}, {32'h0, v.wdata});
    // Garbage command held during the transfer must be ignored.
    req_write_i = ~v.wr;
    req_addr_i  = ~v.addr;
    req_wdata_i = ~v.wdata;
    pen = 0;
    for (int i = 0; i <= v.waits; i++) begin
      @(negedge PCLK);
      if (PSEL === 1'b1 && PENABLE === 1'b1) pen++;
      chk("paddr_stable", {32'h0, PADDR}, {32'h0, v.addr});
      if (i == v.waits) begin
        PREADY      = 1'b1;
        PRDATA      = v.prdata;
        PSLVERR     = v.slverr;
        req_valid_i = 1'b0;
      end
    end
    @(negedge PCLK);
    chk("penable_cycles", 64'(pen), 64'(v.waits + 1));
    chk("rsp_valid_pulse", {63'h0, rsp_valid_o}, 64'h1);
    chk("idle_psel", {63'h0, PSEL}, 64'h0);
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'hBAD1_BAD1;
    @(negedge PCLK);
    chk("rsp_valid_single", {63'h0, rsp_valid_o}, 64'h0);
    chk("rdata_hold", {32'h0, rsp_rdata_o}, {32'h0, v.exp_rdata});
    chk("err_hold", {63'h0, rsp_err_o}, {63'h0, v.exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //         wr    addr          wdata         waits prdata        slverr exp_rdata     exp_err
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 3, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0030, 32'h5555_0000, 1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0034, 32'h0000_0001, 0, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0F0F_0F0F, 2, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1};

    PRESET      = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    PREADY      = 1'b0;
    PRDATA      = '0;
    PSLVERR     = 1'b0;

    // Reset state
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", {63'h0, PSEL}, 64'h0);
    chk("rst_penable", {63'h0, PENABLE}, 64'h0);
    chk("rst_paddr", {32'h0, PADDR}, 64'h0);
    chk("rst_pwdata", {32'h0, PWDATA}, 64'h0);
    chk("rst_pwrite", {63'h0, PWRITE}, 64'h0);
    chk("rst_rsp_valid", {63'h0, rsp_valid_o}, 64'h0);
    chk("rst_rsp_rdata", {32'h0, rsp_rdata_o}, 64'h0);
    chk("rst_rsp_err", {63'h0, rsp_err_o}, 64'h0);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_ready", {63'h0, req_ready_o}, 64'h1);

    for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

    // Back-to-back: req_valid held high, PREADY tied high -> one accept every 3 cycles.
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    for (int k = 0; k < 14; k++) begin
      logic exp_busy;
      exp_busy = (k < 12) && (k % 3 != 0);
      chk("b2b_psel", {63'h0, PSEL}, {63'h0, exp_busy});
      chk("b2b_ready", {63'h0, req_ready_o}, {63'h0, !exp_busy});
      chk("b2b_rsp_valid", {63'h0, rsp_valid_o},
          {63'h0, (k >= 3) && (k <= 12) && (k % 3 == 0)});
      if (k < 12 && k % 3 == 0) begin
        logic [31:0] idx;
        idx         = 32'(k / 3);
        req_valid_i = 1'b1;
        req_write_i = ~idx[0];
        req_addr_i  = 32'h100 + idx * 4;
        req_wdata_i = 32'h7700_0000 + idx;
        PRDATA      = 32'hB2B0_0000 + idx;
        exp_q.push_back({1'b0, idx[0] ? (32'hB2B0_0000 + idx) : 32'h0});
      end
      if (k == 12) req_valid_i = 1'b0;
      @(negedge PCLK);
    end
    PREADY = 1'b0;

    // Reset in the middle of ACCESS: the transfer is dropped without a response.
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 32'h50;
    @(negedge PCLK);
    req_valid_i = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_rst_penable", {63'h0, PENABLE}, 64'h1);
    #1 PRESET = 1'b1;
    #1;
    chk("midrst_psel", {63'h0, PSEL}, 64'h0);
    chk("midrst_penable", {63'h0, PENABLE}, 64'h0);
    chk("midrst_rsp_valid", {63'h0, rsp_valid_o}, 64'h0);
    chk("midrst_rdata", {32'h0, rsp_rdata_o}, 64'h0);
    chk("midrst_paddr", {32'h0, PADDR}, 64'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    chk("postrst_rsp_valid", {63'h0, rsp_valid_o}, 64'h0);
    // Accepted on the first edge after release.
    run_xfer(vecs[3]);
    run_xfer(vecs[0]);

`ifdef APB_MASTER_TIMEOUT_EN
    begin
      int n;
      // PREADY never arrives: abort after 5 ACCESS cycles with an error.
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = 32'h60;
      PREADY      = 1'b0;
      exp_q.push_back({1'b1, 32'h0});
      @(negedge PCLK);
      req_valid_i = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge PCLK);
        if (PENABLE !== 1'b1) break;
        n++;
      end
      chk("to_access_cycles", 64'(n), 64'd5);
      chk("to_rsp_valid", {63'h0, rsp_valid_o}, 64'h1);
      chk("to_psel", {63'h0, PSEL}, 64'h0);
      @(negedge PCLK);
      // PREADY on the timeout cycle completes normally.
      req_valid_i = 1'b1;
      req_addr_i  = 32'h64;
      exp_q.push_back({1'b0, 32'h7E57_7E57});
      @(negedge PCLK);
      req_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge PCLK);
        chk("to2_penable", {63'h0, PENABLE}, 64'h1);
        if (i == 4) begin
          PREADY  = 1'b1;
          PRDATA  = 32'h7E57_7E57;
          PSLVERR = 1'b0;
        end
      end
      @(negedge PCLK);
      chk("to2_rsp_valid", {63'h0, rsp_valid_o}, 64'h1);
      PREADY = 1'b0;
      @(negedge PCLK);
    end
`endif

    @(negedge PCLK);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
